// File: rtl/mm_sequencer_if.sv
// rtl/mm_sequencer_if.sv - operand, result and MMHelper bus bundle for mm_sequencer
//
// Purpose: groups the three streams/buses that mm_sequencer owns.
//   operand stream : in_valid, in_ready, in_data
//   result stream  : res_valid, res_ready, res_data, res_i, res_j
//   MMHelper bus   : mm_wr_enable, mm_compute_enable, mm_is_first_mat,
//                    mm_in_data, mm_i, mm_j, mm_match_dim, mm_out_data
// Modports:
//   master : the sequencer side
//   slave  : the operand source, result sink and MMHelper side
interface mm_sequencer_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int OUT_DATA_WIDTH = 20
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     in_data;

   logic                      res_valid;
   logic                      res_ready;
   logic [OUT_DATA_WIDTH-1:0] res_data;
   logic [3:0]                res_i;
   logic [3:0]                res_j;

   logic                      mm_wr_enable;
   logic                      mm_compute_enable;
   logic                      mm_is_first_mat;
   logic [DATA_WIDTH-1:0]     mm_in_data;
   logic [3:0]                mm_i;
   logic [3:0]                mm_j;
   logic [3:0]                mm_match_dim;
   logic [OUT_DATA_WIDTH-1:0] mm_out_data;

   modport master (
      input  in_valid, in_data, res_ready, mm_out_data,
      output in_ready, res_valid, res_data, res_i, res_j,
             mm_wr_enable, mm_compute_enable, mm_is_first_mat,
             mm_in_data, mm_i, mm_j, mm_match_dim
   );

   modport slave (
      output in_valid, in_data, res_ready, mm_out_data,
      input  in_ready, res_valid, res_data, res_i, res_j,
             mm_wr_enable, mm_compute_enable, mm_is_first_mat,
             mm_in_data, mm_i, mm_j, mm_match_dim
   );
endinterface

// File: rtl/mm_sequencer.sv
// rtl/mm_sequencer.sv - start/done job controller for one MMHelper matrix-multiply datapath
//
// Purpose: loads A then B (row-major) from the operand stream into MMHelper,
// then issues one compute per output element and returns C row-major on the
// result stream.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start, dim   : job start pulse (honoured only when idle) and square dimension
//   busy         : high whenever not idle
//   done, err    : one-cycle end-of-job pulse; err flags dim of 0 or above N
//   bus (master) : operand stream, result stream and MMHelper drive/return
module mm_sequencer #(
   parameter int DATA_WIDTH     = 8,
   parameter int N              = 4,
   parameter int OUT_DATA_WIDTH = 20
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [3:0]     dim,
   output logic           busy,
   output logic           done,
   output logic           err,
   mm_sequencer_if.master bus
);

   localparam logic [3:0] N_MAX = 4'(N);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_ISSUE, S_CAPTURE, S_OUTPUT, S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [3:0]                dim_q, dim_d;
   logic [3:0]                r_q, r_d;
   logic [3:0]                c_q, c_d;
   logic                      err_q, err_d;
   logic                      res_valid_q, res_valid_d;
   logic [OUT_DATA_WIDTH-1:0] res_data_q, res_data_d;
   logic [3:0]                res_i_q, res_i_d;
   logic [3:0]                res_j_q, res_j_d;

   logic                      loading;
   logic                      dim_ok;
   logic [3:0]                dim_last;
   logic                      row_end;
   logic                      last_elem;
   logic [3:0]                r_next;
   logic [3:0]                c_next;
   logic [DATA_WIDTH-1:0]     in_data_w;

   assign loading   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign dim_ok    = (dim != 4'd0) && (dim <= N_MAX);
   assign dim_last  = dim_q - 4'd1;
   assign row_end   = (c_q == dim_last);
   assign last_elem = row_end && (r_q == dim_last);
   // Row-major walk over the dim x dim grid shared by loading and issuing.
   assign c_next    = row_end ? 4'd0 : c_q + 4'd1;
   assign r_next    = row_end ? r_q + 4'd1 : r_q;

   always_comb begin
      state_d     = state_q;
      dim_d       = dim_q;
      r_d         = r_q;
      c_d         = c_q;
      err_d       = err_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_i_d     = res_i_q;
      res_j_d     = res_j_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dim_d   = dim;
               err_d   = !dim_ok;
               r_d     = 4'd0;
               c_d     = 4'd0;
               state_d = dim_ok ? S_LOAD_A : S_DONE;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            if (bus.in_valid) begin
               if (last_elem) begin
                  r_d     = 4'd0;
                  c_d     = 4'd0;
                  state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_ISSUE;
               end else begin
                  r_d = r_next;
                  c_d = c_next;
               end
            end
         end
         S_ISSUE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            // MMHelper's registered result is valid one cycle after compute.
            res_data_d  = bus.mm_out_data;
            res_i_d     = r_q;
            res_j_d     = c_q;
            res_valid_d = 1'b1;
            state_d     = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               if (last_elem) begin
                  r_d     = 4'd0;
                  c_d     = 4'd0;
                  state_d = S_DONE;
               end else begin
                  r_d     = r_next;
                  c_d     = c_next;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         dim_q       <= 4'd0;
         r_q         <= 4'd0;
         c_q         <= 4'd0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_i_q     <= 4'd0;
         res_j_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         dim_q       <= dim_d;
         r_q         <= r_d;
         c_q         <= c_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_i_q     <= res_i_d;
         res_j_q     <= res_j_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign err  = err_q;

   assign in_data_w             = bus.in_data;
   assign bus.in_ready          = loading;
   // MMHelper writes on the same edge the operand beat is accepted.
   assign bus.mm_wr_enable      = bus.in_valid && loading;
   assign bus.mm_in_data        = in_data_w;
   assign bus.mm_is_first_mat   = (state_q == S_LOAD_A);
   assign bus.mm_compute_enable = (state_q == S_ISSUE);
   assign bus.mm_i              = r_q;
   assign bus.mm_j              = c_q;
   assign bus.mm_match_dim      = busy ? dim_q : 4'd0;

   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_i     = res_i_q;
   assign bus.res_j     = res_j_q;

endmodule

// File: tb/tb_mm_sequencer.sv
// tb/tb_mm_sequencer.sv - directed self-checking bench for mm_sequencer with an MMHelper model
module tb_mm_sequencer;

   localparam int DW  = 8;
   localparam int ODW = 20;
   localparam int N   = 4;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] dim   = 4'd0;
   logic       busy, done, err;

   mm_sequencer_if #(.DATA_WIDTH(DW), .OUT_DATA_WIDTH(ODW)) bus ();

   mm_sequencer #(.DATA_WIDTH(DW), .N(N), .OUT_DATA_WIDTH(ODW)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .dim   (dim),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // MMHelper model: two register files plus a registered inner product.
   logic signed [7:0] a_mem [4][4];
   logic signed [7:0] b_mem [4][4];
   logic [ODW-1:0]    mm_out_q;

   function automatic int dot(input logic [3:0] i, input logic [3:0] j, input logic [3:0] md);
      int s;
      s = 0;
      for (int k = 0; k < N; k++)
         if (k < int'(md) && i < 4'd4 && j < 4'd4)
            s += int'(a_mem[i[1:0]][k]) * int'(b_mem[k][j[1:0]]);
      return s;
   endfunction

   always @(posedge clk) begin
      if (bus.mm_wr_enable && bus.mm_i < 4'd4 && bus.mm_j < 4'd4) begin
         if (bus.mm_is_first_mat) a_mem[bus.mm_i[1:0]][bus.mm_j[1:0]] <= bus.mm_in_data;
         else                     b_mem[bus.mm_i[1:0]][bus.mm_j[1:0]] <= bus.mm_in_data;
      end
      if (bus.mm_compute_enable)
         mm_out_q <= ODW'(dot(bus.mm_i, bus.mm_j, bus.mm_match_dim));
   end
   assign bus.mm_out_data = mm_out_q;

   // Result/done monitor, sampled on the falling edge.
   int cyc = 0;
   int cap_d [256];
   int cap_i [256];
   int cap_j [256];
   int cap_c [256];
   int n_cap = 0;
   int done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.res_valid && bus.res_ready && n_cap < 256) begin
            cap_d[n_cap] = int'($signed(bus.res_data));
            cap_i[n_cap] = int'(bus.res_i);
            cap_j[n_cap] = int'(bus.res_j);
            cap_c[n_cap] = cyc;
            n_cap++;
         end
         if (done) done_cnt++;
      end
   end

   logic [7:0] ops [32];

   task automatic run_job(input logic [3:0] d, input int nops, input int gap,
                          output int base, output int nres, output int ndone, output bit to);
      int k, t, dbase;
      bit acc;
      base  = n_cap;
      dbase = done_cnt;
      @(posedge clk); #1; start = 1'b1; dim = d;
      @(posedge clk); #1; start = 1'b0;
      k = 0;
      t = 0;
      while (k < nops && t < 400) begin
         bus.in_valid = (gap == 0) || ((t % gap) != gap - 1);
         bus.in_data  = ops[k];
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) k++;
         t++;
      end
      bus.in_valid = 1'b0;
      while (done_cnt == dbase && t < 1000) begin
         @(negedge clk);
         t++;
      end
      to = (done_cnt == dbase);
      repeat (3) @(negedge clk);
      nres  = n_cap - base;
      ndone = done_cnt - dbase;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] got [12];
      string nm [12];
      repeat (2) @(negedge clk);
      for (int pass = 0; pass < 2; pass++) begin
         got[0]  = 32'(busy);                  nm[0]  = "rst_busy";
         got[1]  = 32'(done);                  nm[1]  = "rst_done";
         got[2]  = 32'(err);                   nm[2]  = "rst_err";
         got[3]  = 32'(bus.in_ready);          nm[3]  = "rst_in_ready";
         got[4]  = 32'(bus.res_valid);         nm[4]  = "rst_res_valid";
         got[5]  = 32'(bus.mm_wr_enable);      nm[5]  = "rst_mm_wr_enable";
         got[6]  = 32'(bus.mm_compute_enable); nm[6]  = "rst_mm_compute_enable";
         got[7]  = 32'(bus.mm_is_first_mat);   nm[7]  = "rst_mm_is_first_mat";
         got[8]  = 32'(bus.res_data);          nm[8]  = "rst_res_data";
         got[9]  = 32'(bus.res_i);             nm[9]  = "rst_res_i";
         got[10] = 32'(bus.res_j);             nm[10] = "rst_res_j";
         got[11] = 32'(bus.mm_match_dim);      nm[11] = "rst_mm_match_dim";
         for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (got[k] !== 32'd0) begin
               n_bad++;
               $display("FAIL %s (pass %0d): got %0h, expected 0", nm[k], pass, got[k]);
            end
         end
         if (pass == 0) begin
            reset = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_dim2_basic();
      int base, nres, ndone;
      bit to;
      int exp_d [4];
      exp_d = '{19, 22, 43, 50};
      for (int k = 0; k < 8; k++) ops[k] = 8'(k + 1);
      run_job(4'd2, 8, 0, base, nres, ndone, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL dim2_timeout: got %0d, expected 0", to); end
      n_cmp++; if (nres !== 4) begin n_bad++; $display("FAIL dim2_count: got %0d, expected 4", nres); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (cap_d[base+k] !== exp_d[k] || cap_i[base+k] !== k / 2 || cap_j[base+k] !== k % 2) begin
            n_bad++;
            $display("FAIL dim2_result%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                     k, cap_i[base+k], cap_j[base+k], cap_d[base+k], k / 2, k % 2, exp_d[k]);
         end
      end
      for (int k = 1; k < 4; k++) begin
         n_cmp++;
         if (cap_c[base+k] - cap_c[base+k-1] !== 3) begin
            n_bad++;
            $display("FAIL dim2_spacing%0d: got %0d cycles, expected 3", k, cap_c[base+k] - cap_c[base+k-1]);
         end
      end
      n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL dim2_done_pulses: got %0d, expected 1", ndone); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL dim2_err: got %0d, expected 0", err); end
   endtask

   task automatic test_dim4_extreme();
      int base, nres, ndone;
      bit to;
      for (int k = 0; k < 32; k++) ops[k] = 8'h80;
      run_job(4'd4, 32, 0, base, nres, ndone, to);
      n_cmp++; if (to !== 1'b0 || nres !== 16) begin n_bad++; $display("FAIL dim4_count: got %0d (timeout %0d), expected 16", nres, to); end
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (cap_d[base+k] !== 65536 || cap_i[base+k] !== k / 4 || cap_j[base+k] !== k % 4) begin
            n_bad++;
            $display("FAIL dim4_max%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=65536",
                     k, cap_i[base+k], cap_j[base+k], cap_d[base+k], k / 4, k % 4);
         end
      end
   endtask

   task automatic test_identity();
      int base, nres, ndone;
      bit to;
      int bv [16];
      bv = '{-1, 2, 3, 4, 5, -6, 7, 8, 9, 10, -11, 12, 13, 14, 15, -128};
      for (int k = 0; k < 16; k++) begin
         ops[k]      = (k / 4 == k % 4) ? 8'd1 : 8'd0;
         ops[16 + k] = bv[k][7:0];
      end
      run_job(4'd4, 32, 0, base, nres, ndone, to);
      n_cmp++; if (to !== 1'b0 || nres !== 16) begin n_bad++; $display("FAIL ident_count: got %0d (timeout %0d), expected 16", nres, to); end
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if (cap_d[base+k] !== bv[k]) begin
            n_bad++;
            $display("FAIL ident%0d: got %0d, expected %0d", k, cap_d[base+k], bv[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int base, nres, ndone;
      bit to;
      int seen;
      int exp_d [4];
      exp_d = '{19, 22, 43, 50};
      for (int k = 0; k < 8; k++) ops[k] = 8'(k + 1);
      bus.res_ready = 1'b0;
      fork
         run_job(4'd2, 8, 3, base, nres, ndone, to);
         begin
            seen = 0;
            for (int t = 0; t < 500 && seen < 4; t++) begin
               @(negedge clk);
               if (bus.res_valid && !bus.res_ready) begin
                  if (seen == 1) begin
                     for (int s = 0; s < 5; s++) begin
                        if (s > 0) @(negedge clk);
                        n_cmp++;
                        if (bus.res_valid !== 1'b1 || bus.res_data !== 20'd22 ||
                            bus.res_i !== 4'd0 || bus.res_j !== 4'd1) begin
                           n_bad++;
                           $display("FAIL bp_hold%0d: got v=%0d (%0d,%0d)=%0d, expected v=1 (0,1)=22",
                                    s, bus.res_valid, bus.res_i, bus.res_j, bus.res_data);
                        end
                     end
                  end
                  @(posedge clk); #1; bus.res_ready = 1'b1;
                  @(posedge clk); #1; bus.res_ready = 1'b0;
                  seen++;
               end
            end
            n_cmp++;
            if (seen !== 4) begin n_bad++; $display("FAIL bp_seen: got %0d, expected 4", seen); end
         end
      join
      bus.res_ready = 1'b1;
      n_cmp++; if (to !== 1'b0 || nres !== 4) begin n_bad++; $display("FAIL bp_count: got %0d (timeout %0d), expected 4", nres, to); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (cap_d[base+k] !== exp_d[k] || cap_i[base+k] !== k / 2 || cap_j[base+k] !== k % 2) begin
            n_bad++;
            $display("FAIL bp_result%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                     k, cap_i[base+k], cap_j[base+k], cap_d[base+k], k / 2, k % 2, exp_d[k]);
         end
      end
   endtask

   task automatic test_bad_dim(input logic [3:0] d);
      int done_at, rdy;
      logic err_at_done;
      done_at     = -1;
      rdy         = 0;
      err_at_done = 1'b0;
      @(posedge clk); #1; start = 1'b1; dim = d;
      @(posedge clk); #1; start = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         if (bus.in_ready) rdy++;
         if (done && done_at < 0) begin
            done_at     = t;
            err_at_done = err;
         end
      end
      n_cmp++; if (done_at < 1 || done_at > 2) begin n_bad++; $display("FAIL bad_dim%0d_done_at: got %0d, expected 1..2", d, done_at); end
      n_cmp++; if (err_at_done !== 1'b1) begin n_bad++; $display("FAIL bad_dim%0d_err_with_done: got %0d, expected 1", d, err_at_done); end
      n_cmp++; if (rdy !== 0) begin n_bad++; $display("FAIL bad_dim%0d_in_ready: got %0d cycles, expected 0", d, rdy); end
      n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL bad_dim%0d_idle: got err=%0d busy=%0d, expected err=1 busy=0", d, err, busy); end
   endtask

   task automatic test_err_clear();
      int base, nres, ndone;
      bit to;
      ops[0] = 8'd3;
      ops[1] = 8'hFC;
      run_job(4'd1, 2, 0, base, nres, ndone, to);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %0d, expected 0", err); end
      n_cmp++;
      if (to !== 1'b0 || nres !== 1 || cap_d[base] !== -12) begin
         n_bad++;
         $display("FAIL dim1_result: got n=%0d val=%0d, expected n=1 val=-12", nres, cap_d[base]);
      end
   endtask

   task automatic test_reset_mid();
      int base, nres, ndone;
      bit to;
      int exp_d [4];
      exp_d = '{10, -2, -10, 31};
      ops[0] = 8'd1;  ops[1] = 8'hFF; ops[2] = 8'd2;  ops[3] = 8'd3;
      ops[4] = 8'd4;  ops[5] = 8'd5;  ops[6] = 8'hFA; ops[7] = 8'd7;
      @(posedge clk); #1; start = 1'b1; dim = 4'd2;
      @(posedge clk); #1; start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = ops[k];
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %0d, expected 1", busy); end
      #2; reset = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.mm_match_dim !== 4'd0) begin
         n_bad++;
         $display("FAIL rmid_abort: got busy=%0d in_ready=%0d match_dim=%0d, expected 0 0 0",
                  busy, bus.in_ready, bus.mm_match_dim);
      end
      @(negedge clk); reset = 1'b0;
      run_job(4'd2, 8, 0, base, nres, ndone, to);
      n_cmp++; if (to !== 1'b0 || nres !== 4) begin n_bad++; $display("FAIL rmid_count: got %0d (timeout %0d), expected 4", nres, to); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (cap_d[base+k] !== exp_d[k]) begin
            n_bad++;
            $display("FAIL rmid_result%0d: got %0d, expected %0d", k, cap_d[base+k], exp_d[k]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int base, nres, ndone;
      bit to;
      int exp_d [4];
      exp_d = '{19, 22, 43, 50};
      for (int k = 0; k < 8; k++) ops[k] = 8'(k + 1);
      fork
         run_job(4'd2, 8, 0, base, nres, ndone, to);
         begin
            repeat (3) @(posedge clk);
            #1; start = 1'b1; dim = 4'd3;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (bus.mm_match_dim !== 4'd2 || busy !== 1'b1) begin
               n_bad++;
               $display("FAIL swb_match_dim: got %0d busy=%0d, expected 2 busy=1", bus.mm_match_dim, busy);
            end
            repeat (12) @(posedge clk);
            #1; start = 1'b1; dim = 4'd1;
            @(posedge clk); #1; start = 1'b0;
         end
      join
      n_cmp++; if (to !== 1'b0 || nres !== 4 || ndone !== 1) begin n_bad++; $display("FAIL swb_counts: got res=%0d done=%0d, expected res=4 done=1", nres, ndone); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (cap_d[base+k] !== exp_d[k] || cap_i[base+k] !== k / 2 || cap_j[base+k] !== k % 2) begin
            n_bad++;
            $display("FAIL swb_result%0d: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                     k, cap_i[base+k], cap_j[base+k], cap_d[base+k], k / 2, k % 2, exp_d[k]);
         end
      end
      n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL swb_idle: got busy=%0d err=%0d, expected 0 0", busy, err); end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'd0;
      bus.res_ready = 1'b1;
      test_reset();
      test_dim2_basic();
      test_dim4_extreme();
      test_identity();
      test_backpressure();
      test_bad_dim(4'd0);
      test_bad_dim(4'd5);
      test_err_clear();
      test_reset_mid();
      test_start_while_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000ns, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
